// File: rtl/mem_bus_arbiter_if.sv
// Shared-memory bus between two cores, the arbiter and one memory port.
// The arbiter takes the slave side; cores and memory together form the master side.
interface mem_bus_arbiter_if;
    logic        req0;
    logic        req1;
    logic        we0;
    logic        we1;
    logic [31:0] addr0;
    logic [31:0] addr1;
    logic [31:0] wdata0;
    logic [31:0] wdata1;
    logic [2:0]  mask0;
    logic [2:0]  mask1;
    logic        gnt0;
    logic        gnt1;
    logic        done0;
    logic        done1;
    logic        err;
    logic [31:0] rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [2:0]  mem_mask;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        busy;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mask0, mask1,
        input  mem_ack, mem_rdata,
        output gnt0, gnt1, done0, done1, err, rdata, busy,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_mask
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mask0, mask1,
        output mem_ack, mem_rdata,
        input  gnt0, gnt1, done0, done1, err, rdata, busy,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_mask
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-core round-robin arbiter for a single shared memory port, with a
// per-transaction ack timeout. All outputs are registered.
module mem_bus_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input logic                clk,
    input logic                reset,
    mem_bus_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

    localparam logic [15:0] WaitLast = 16'(TIMEOUT - 1);

    state_e      state_q;
    logic        ptr_q;
    logic        owner_q;
    logic [15:0] wait_cnt_q;
    logic        err_q;
    logic        gnt0_q;
    logic        gnt1_q;
    logic        done0_q;
    logic        done1_q;
    logic        busy_q;
    logic        mem_req_q;
    logic        mem_we_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic [2:0]  mem_mask_q;
    logic [31:0] rdata_q;

    logic sel;

    // Pointer only matters on a tie; a lone requester always wins.
    always_comb begin
        sel = 1'b0;
        if (bus.req0 && bus.req1) begin
            sel = ptr_q;
        end else begin
            sel = bus.req1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            ptr_q       <= 1'b0;
            owner_q     <= 1'b0;
            wait_cnt_q  <= '0;
            err_q       <= 1'b0;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            done0_q     <= 1'b0;
            done1_q     <= 1'b0;
            busy_q      <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_mask_q  <= '0;
            rdata_q     <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus.req0 || bus.req1) begin
                        owner_q     <= sel;
                        mem_we_q    <= sel ? bus.we1    : bus.we0;
                        mem_addr_q  <= sel ? bus.addr1  : bus.addr0;
                        mem_wdata_q <= sel ? bus.wdata1 : bus.wdata0;
                        mem_mask_q  <= sel ? bus.mask1  : bus.mask0;
                        wait_cnt_q  <= '0;
                        err_q       <= 1'b0;
                        gnt0_q      <= ~sel;
                        gnt1_q      <= sel;
                        busy_q      <= 1'b1;
                        mem_req_q   <= 1'b1;
                        state_q     <= StBusy;
                    end
                end
                StBusy: begin
                    // Ack wins over timeout when both land on the last wait cycle.
                    if (bus.mem_ack) begin
                        rdata_q   <= bus.mem_rdata;
                        err_q     <= 1'b0;
                        done0_q   <= ~owner_q;
                        done1_q   <= owner_q;
                        mem_req_q <= 1'b0;
                        state_q   <= StResp;
                    end else if (wait_cnt_q == WaitLast) begin
                        err_q     <= 1'b1;
                        done0_q   <= ~owner_q;
                        done1_q   <= owner_q;
                        mem_req_q <= 1'b0;
                        state_q   <= StResp;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 16'd1;
                    end
                end
                StResp: begin
                    ptr_q   <= ~owner_q;
                    err_q   <= 1'b0;
                    done0_q <= 1'b0;
                    done1_q <= 1'b0;
                    gnt0_q  <= 1'b0;
                    gnt1_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.gnt0      = gnt0_q;
    assign bus.gnt1      = gnt1_q;
    assign bus.done0     = done0_q;
    assign bus.done1     = done1_q;
    assign bus.err       = err_q;
    assign bus.rdata     = rdata_q;
    assign bus.busy      = busy_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_mask  = mem_mask_q;

    gnt_onehot_a: assert property (@(posedge clk) disable iff (reset) !(gnt0_q && gnt1_q));
    done_onehot_a: assert property (@(posedge clk) disable iff (reset) !(done0_q && done1_q));

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed and randomized bench for mem_bus_arbiter against a transaction-level model
// (round-robin pointer, latched request fields, timeout budget in cycles).
module tb_mem_bus_arbiter;

    localparam int unsigned TO = 8;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    mem_bus_arbiter_if bus ();

    mem_bus_arbiter #(.TIMEOUT(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;

    // Model state: which core wins a tie next, and the last captured load data.
    bit          exp_ptr;
    logic [31:0] exp_rdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        chk1("gnt_exclusive", bus.gnt0 & bus.gnt1, 1'b0);
        chk1("done_exclusive", bus.done0 & bus.done1, 1'b0);
    endtask

    function automatic bit pick(input bit r0, input bit r1, input bit p);
        return (r0 && r1) ? p : r1;
    endfunction

    task automatic set_core(input bit c);
        if (c) begin
            bus.req1   = 1'b1;
            bus.we1    = 1'($urandom);
            bus.addr1  = $urandom;
            bus.wdata1 = $urandom;
            bus.mask1  = 3'($urandom);
        end else begin
            bus.req0   = 1'b1;
            bus.we0    = 1'($urandom);
            bus.addr0  = $urandom;
            bus.wdata0 = $urandom;
            bus.mask0  = 3'($urandom);
        end
    endtask

    task automatic scramble(input bit c);
        if (c) begin
            bus.we1    = ~bus.we1;
            bus.addr1  = $urandom;
            bus.wdata1 = $urandom;
            bus.mask1  = 3'($urandom);
            if ($urandom_range(0, 3) == 0) bus.req1 = 1'b0;
        end else begin
            bus.we0    = ~bus.we0;
            bus.addr0  = $urandom;
            bus.wdata0 = $urandom;
            bus.mask0  = 3'($urandom);
            if ($urandom_range(0, 3) == 0) bus.req0 = 1'b0;
        end
    endtask

    task automatic chk_latched(input logic e_we, input logic [31:0] e_addr,
                               input logic [31:0] e_wdata, input logic [2:0] e_mask);
        chk1("mem_we", bus.mem_we, e_we);
        chk("mem_addr", bus.mem_addr, e_addr);
        chk("mem_wdata", bus.mem_wdata, e_wdata);
        chk("mem_mask", 32'(bus.mem_mask), 32'(e_mask));
    endtask

    // Requests are already driven and the arbiter is idle; delay >= TO means no ack.
    task automatic run_txn(input bit owner, input int delay, input logic [31:0] rd,
                           input bit scr);
        logic        e_we;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic [2:0]  e_mask;
        bit          to;
        int          n;
        e_we    = owner ? bus.we1    : bus.we0;
        e_addr  = owner ? bus.addr1  : bus.addr0;
        e_wdata = owner ? bus.wdata1 : bus.wdata0;
        e_mask  = owner ? bus.mask1  : bus.mask0;
        to      = (delay >= int'(TO));
        n       = to ? int'(TO) - 1 : delay;
        bus.mem_ack = 1'b0;
        tick();
        chk1("gnt0_busy", bus.gnt0, ~owner);
        chk1("gnt1_busy", bus.gnt1, owner);
        chk1("mem_req_rise", bus.mem_req, 1'b1);
        chk1("busy_rise", bus.busy, 1'b1);
        chk_latched(e_we, e_addr, e_wdata, e_mask);
        for (int i = 0; i < n; i++) begin
            if (scr) scramble(owner);
            tick();
            chk1("mem_req_hold", bus.mem_req, 1'b1);
            chk1("no_early_done", bus.done0 | bus.done1, 1'b0);
            chk_latched(e_we, e_addr, e_wdata, e_mask);
        end
        bus.mem_ack   = ~to;
        bus.mem_rdata = rd;
        tick();
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = $urandom;
        if (!to) exp_rdata = rd;
        chk1("done0", bus.done0, ~owner);
        chk1("done1", bus.done1, owner);
        chk1("err", bus.err, to);
        chk("rdata", bus.rdata, exp_rdata);
        chk1("mem_req_resp", bus.mem_req, 1'b0);
        chk1("busy_resp", bus.busy, 1'b1);
        chk1("gnt_resp", owner ? bus.gnt1 : bus.gnt0, 1'b1);
        exp_ptr = ~owner;
    endtask

    task automatic idle_check();
        tick();
        chk1("busy_idle", bus.busy, 1'b0);
        chk1("gnt_idle", bus.gnt0 | bus.gnt1, 1'b0);
        chk1("done_idle", bus.done0 | bus.done1, 1'b0);
        chk1("err_idle", bus.err, 1'b0);
        chk1("mem_req_idle", bus.mem_req, 1'b0);
        chk("rdata_idle", bus.rdata, exp_rdata);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        tick();
        tick();
        chk1("rst_busy", bus.busy, 1'b0);
        chk1("rst_gnt", bus.gnt0 | bus.gnt1, 1'b0);
        chk1("rst_done", bus.done0 | bus.done1, 1'b0);
        chk1("rst_err", bus.err, 1'b0);
        chk1("rst_mem_req", bus.mem_req, 1'b0);
        chk_latched(1'b0, 32'h0, 32'h0, 3'h0);
        chk("rst_rdata", bus.rdata, 32'h0);
        reset     = 1'b0;
        exp_ptr   = 1'b0;
        exp_rdata = 32'h0;
    endtask

    initial begin
        bit own;
        int dly;
        reset = 1'b1;
        bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0; bus.mask0 = '0;
        bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0; bus.mask1 = '0;
        bus.mem_ack = 1'b0;
        bus.mem_rdata = '0;
        apply_reset();

        // Single load, ack three cycles after mem_req rises.
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 32'h100; bus.mask0 = 3'b010;
        run_txn(1'b0, 3, 32'hDEADBEEF, 1'b0);
        bus.req0 = 1'b0;
        idle_check();

        // Contention from reset: core 0, then core 1, then core 0 again.
        apply_reset();
        set_core(1'b0);
        set_core(1'b1);
        run_txn(1'b0, 1, $urandom, 1'b0);
        idle_check();
        run_txn(1'b1, 0, $urandom, 1'b0);
        idle_check();
        run_txn(1'b0, 2, $urandom, 1'b0);
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        idle_check();

        // Store from core 1 with its inputs changing under the transaction.
        bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 32'h200;
        bus.wdata1 = 32'h12345678; bus.mask1 = 3'b010;
        run_txn(1'b1, 4, 32'hCAFEF00D, 1'b1);
        bus.req1 = 1'b0;
        idle_check();

        // No ack: timeout after TO busy cycles, rdata untouched.
        set_core(1'b0);
        run_txn(1'b0, int'(TO), 32'hBAD0BAD0, 1'b0);
        bus.req0 = 1'b0;
        idle_check();

        // Ack on the very last allowed cycle still completes cleanly.
        set_core(1'b1);
        run_txn(1'b1, int'(TO) - 1, 32'h0F0F0F0F, 1'b0);
        bus.req1 = 1'b0;
        idle_check();

        // Reset in the second busy cycle.
        set_core(1'b0);
        tick();
        tick();
        chk1("mem_req_pre_rst", bus.mem_req, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.req0 = 1'b0;
        chk1("mid_rst_mem_req", bus.mem_req, 1'b0);
        chk1("mid_rst_busy", bus.busy, 1'b0);
        chk1("mid_rst_done", bus.done0 | bus.done1, 1'b0);
        chk("mid_rst_rdata", bus.rdata, 32'h0);
        exp_ptr   = 1'b0;
        exp_rdata = 32'h0;
        set_core(1'b1);
        run_txn(1'b1, 2, 32'h600DF00D, 1'b0);
        bus.req1 = 1'b0;
        idle_check();

        // Spurious ack while idle.
        bus.mem_ack = 1'b1;
        bus.mem_rdata = 32'h55AA55AA;
        tick();
        bus.mem_ack = 1'b0;
        chk1("spur_done", bus.done0 | bus.done1, 1'b0);
        chk1("spur_busy", bus.busy, 1'b0);
        chk("spur_rdata", bus.rdata, exp_rdata);
        idle_check();

        // Randomized traffic; the loser of a tie keeps its request held.
        for (int it = 0; it < 40; it++) begin
            if (!bus.req0 && !bus.req1 && $urandom_range(0, 3) == 0) begin
                bus.mem_ack = 1'b1;
                bus.mem_rdata = $urandom;
                tick();
                bus.mem_ack = 1'b0;
                chk1("rnd_spur_done", bus.done0 | bus.done1, 1'b0);
                chk("rnd_spur_rdata", bus.rdata, exp_rdata);
            end
            if (!bus.req0 && $urandom_range(0, 1) == 1) set_core(1'b0);
            if (!bus.req1 && $urandom_range(0, 1) == 1) set_core(1'b1);
            if (!bus.req0 && !bus.req1) set_core(1'($urandom));
            own = pick(bus.req0, bus.req1, exp_ptr);
            dly = int'($urandom_range(0, TO + 1));
            run_txn(own, dly, $urandom, 1'b1);
            if (own) bus.req1 = 1'b0;
            else     bus.req0 = 1'b0;
            idle_check();
        end

        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        idle_check();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum cycles in BUSY without mem_ack before the transaction is aborted (1..65535).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req0, req1  input  1  core 0 / core 1 memory request; held high by the core until its done pulse.
REQ-005 we0, we1  input  1  request is a store (1) or a load (0).
REQ-006 addr0, addr1  input  32  byte address.
REQ-007 wdata0, wdata1  input  32  store data.
REQ-008 mask0, mask1  input  3  func3-encoded access size (byte/half/word, signed/unsigned).
REQ-009 gnt0, gnt1  output  1  level: core owns the bus (BUSY or RESP state).
REQ-010 done0, done1  output  1  one-cycle completion pulse to the owning core.
REQ-011 err  output  1  one-cycle pulse coincident with done when the transaction timed out.
REQ-012 rdata  output  32  load data returned to both cores; valid on the done cycle and held until the next capture.
REQ-013 mem_req  output  1  request to shared memory; high for the whole BUSY state.
REQ-014 mem_we, mem_addr (32), mem_wdata (32), mem_mask (3)  outputs  latched copies of the owner's request.
REQ-015 mem_ack  input  1  memory completion; mem_rdata (input, 32) valid in the same cycle.
REQ-016 busy  output  1  high in any state other than IDLE.

Function
REQ-017 The FSM SHALL have three states: IDLE, BUSY, RESP.
REQ-018 In IDLE with exactly one req high, that core SHALL be selected; with both high, the core indicated by the priority pointer SHALL be selected.
REQ-019 On selection, the we/addr/wdata/mask of the selected core SHALL be latched into the mem_* registers, owner SHALL be recorded, and the FSM SHALL enter BUSY, so that mem_req rises one cycle after req is sampled.
REQ-020 In BUSY, mem_req and all mem_* outputs SHALL be held stable regardless of changes to the requester's inputs.
REQ-021 In BUSY with mem_ack=1, mem_rdata SHALL be captured into rdata (loads and stores alike) and the FSM SHALL enter RESP; mem_req SHALL be 0 in RESP.
REQ-022 A 16-bit wait counter SHALL clear on BUSY entry and increment each BUSY cycle without ack; when it reaches TIMEOUT-1 without ack, the FSM SHALL enter RESP with an error flag set and rdata left unchanged.
REQ-023 mem_ack arriving in the same cycle the count reaches TIMEOUT-1 SHALL complete normally, with no error.
REQ-024 In RESP, done<owner>=1 for exactly one cycle, err equals the error flag, the priority pointer SHALL be set to the non-owner, and the FSM SHALL return to IDLE unconditionally.
REQ-025 req is ignored in RESP; a core holding req through RESP is re-arbitrated in the following IDLE cycle, where the flipped pointer gives the other core precedence.
REQ-026 A req deasserting during BUSY SHALL NOT abort the transaction; it completes and the done pulse is still issued.
REQ-027 mem_ack while in IDLE or RESP SHALL be ignored.
REQ-028 Minimum transaction latency: req sampled at cycle 0, mem_req at cycle 1, ack at cycle 1, done at cycle 2, IDLE at cycle 3.
REQ-029 gnt0/gnt1 SHALL be mutually exclusive, and done0/done1 SHALL never both be high.

Reset
REQ-030 With reset high at a clock edge, the FSM SHALL enter IDLE, the priority pointer SHALL be 0 (core 0 preferred), the error flag and wait counter SHALL be 0, and rdata and mem_addr/mem_wdata/mem_mask/mem_we SHALL be 0.
REQ-031 While in reset, the outputs gnt*, done*, err, mem_req and busy SHALL be 0.
REQ-032 Reset mid-transaction SHALL drop mem_req at the next edge, issue no done pulse, and leave the arbiter in IDLE.

Verification
REQ-033 Single load: req0=1, we0=0, addr0=0x100, ack 3 cycles after mem_req with mem_rdata=0xDEADBEEF -> mem_addr=0x100, done0 one cycle after ack, rdata=0xDEADBEEF, err=0.
REQ-034 Contention: req0 and req1 both rise in the same cycle after reset, both held -> core 0 served first, then core 1, then core 0; gnt0/gnt1 never both high.
REQ-035 Store: req1=1, we1=1, addr1=0x200, wdata1=0x12345678, mask1=3'b010; req1 inputs changed during BUSY -> mem_* hold the latched values until ack; done1 is pulsed.
REQ-036 Timeout, TIMEOUT=8, no ack -> mem_req high for 8 cycles, then done0=1 and err=1 in the same cycle, and rdata unchanged.
REQ-037 Reset asserted in the 2nd BUSY cycle -> mem_req=0 and busy=0 after the edge, no done pulse, and a subsequent req1 is granted normally.
REQ-038 Spurious mem_ack in IDLE -> no done pulse and rdata unchanged.
